// File: rtl/lsu_burst.sv
// lsu_burst: RV32I load/store unit issuing one or two memory beats per access.
// A lane-crossing access is split into an aligned beat plus a follow-up beat at
// the next aligned word; load bytes from both beats are merged little-endian.
module lsu_burst #(
  parameter int ADDR_WIDTH     = 31,
  parameter int DATA_WIDTH     = 31,
  parameter int MISALIGNED_EN  = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_start,
  input  logic                  i_store,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH:0]   i_addr,
  input  logic [31:0]           i_store_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_load_data,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [(DATA_WIDTH+1)/8-1:0] o_mem_be,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH:0]   i_mem_rdata
);

  localparam int DBW  = DATA_WIDTH + 1;
  localparam int NB   = DBW / 8;
  localparam int OFFW = (NB == 8) ? 3 : 2;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t                state;
  logic                  store_r;
  logic [2:0]            f3_r;
  logic [OFFW-1:0]       off_r;
  logic                  cross_r;
  logic [ADDR_WIDTH:0]   a1_r;
  logic [NB-1:0]         be1_r;
  logic [DBW-1:0]        wd1_r;
  logic [DBW-1:0]        rd0_r;
  logic [31:0]           tcnt;

  logic [OFFW-1:0]       cap_off;
  logic [3:0]            size_mask;
  logic [2*NB-1:0]       cap_be;
  logic [2*DBW-1:0]      cap_wd;
  logic                  cap_cross;
  logic                  cap_err;
  logic [ADDR_WIDTH:0]   cap_a0;
  logic [ADDR_WIDTH:0]   cap_a1;
  logic                  to_hit;

  // Shift the two-beat window right by the byte offset, then size/sign-extend.
  function automatic logic [31:0] ld_ext(input logic [2*DBW-1:0] w,
                                         input logic [OFFW-1:0]  off,
                                         input logic [2:0]       f3);
    logic [2*DBW-1:0] s;
    s = w >> {off, 3'b000};
    case (f3)
      3'b000:  ld_ext = {{24{s[7]}}, s[7:0]};
      3'b001:  ld_ext = {{16{s[15]}}, s[15:0]};
      3'b100:  ld_ext = {24'd0, s[7:0]};
      3'b101:  ld_ext = {16'd0, s[15:0]};
      default: ld_ext = s[31:0];
    endcase
  endfunction

  // Request decode: byte enables and write data laid out over a two-beat window.
  always_comb begin
    cap_off = i_addr[OFFW-1:0];
    case (i_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    cap_be    = {{(2*NB-4){1'b0}}, size_mask} << cap_off;
    cap_wd    = {{(2*DBW-32){1'b0}}, i_store_data} << {cap_off, 3'b000};
    cap_cross = |cap_be[2*NB-1:NB];
    cap_a0    = {i_addr[ADDR_WIDTH:OFFW], {OFFW{1'b0}}};
    cap_a1    = cap_a0 + (ADDR_WIDTH+1)'(NB);
    cap_err   = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) ||
                (i_store && i_funct3[2]) || (cap_cross && (MISALIGNED_EN == 0));
  end

  assign to_hit    = (TIMEOUT_CYCLES != 0) && (tcnt == TO_LAST);
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == RESP);
  assign o_mem_req = (state == BEAT0) || (state == BEAT1);

  // Main FSM; every register is frozen while clk_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      store_r     <= 1'b0;
      f3_r        <= 3'd0;
      off_r       <= '0;
      cross_r     <= 1'b0;
      a1_r        <= '0;
      be1_r       <= '0;
      wd1_r       <= '0;
      rd0_r       <= '0;
      tcnt        <= 32'd0;
      o_err       <= 1'b0;
      o_load_data <= 32'd0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (i_start) begin
            store_r <= i_store;
            f3_r    <= i_funct3;
            off_r   <= cap_off;
            cross_r <= cap_cross;
            a1_r    <= cap_a1;
            be1_r   <= cap_be[2*NB-1:NB];
            wd1_r   <= cap_wd[2*DBW-1:DBW];
            tcnt    <= 32'd0;
            if (cap_err) begin
              state       <= RESP;
              o_err       <= 1'b1;
              o_load_data <= 32'd0;
            end else begin
              state       <= BEAT0;
              o_err       <= 1'b0;
              o_mem_we    <= i_store;
              o_mem_addr  <= cap_a0;
              o_mem_be    <= cap_be[NB-1:0];
              o_mem_wdata <= cap_wd[DBW-1:0];
            end
          end
        end
        BEAT0: begin
          if (i_mem_ready) begin
            tcnt <= 32'd0;
            if (cross_r) begin
              state       <= BEAT1;
              rd0_r       <= i_mem_rdata;
              o_mem_addr  <= a1_r;
              o_mem_be    <= be1_r;
              o_mem_wdata <= wd1_r;
            end else begin
              state       <= RESP;
              o_mem_we    <= 1'b0;
              o_mem_be    <= '0;
              o_load_data <= store_r ? 32'd0 :
                             ld_ext({{DBW{1'b0}}, i_mem_rdata}, off_r, f3_r);
            end
          end else if (to_hit) begin
            state       <= RESP;
            o_err       <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_load_data <= 32'd0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        BEAT1: begin
          if (i_mem_ready) begin
            state       <= RESP;
            tcnt        <= 32'd0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_load_data <= store_r ? 32'd0 :
                           ld_ext({i_mem_rdata, rd0_r}, off_r, f3_r);
          end else if (to_hit) begin
            state       <= RESP;
            o_err       <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_load_data <= 32'd0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          o_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_burst.sv
// Testbench for lsu_burst: vector table driven through a beat/response
// scoreboard, plus hand sequences for timeout, wait states, clk_en and reset.
module tb_lsu_burst;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        i_start;
  logic        start_b;
  logic        i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;

  logic        o_busy, o_done, o_err, o_mem_req, o_mem_we;
  logic [31:0] o_load_data, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  logic        nb_busy, nb_done, nb_err, nb_req, nb_we;
  logic [31:0] nb_load, nb_addr, nb_wdata;
  logic [3:0]  nb_be;

  lsu_burst #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .MISALIGNED_EN(1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_start(i_start), .i_store(i_store),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_store_data(i_store_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_load_data(o_load_data),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata));

  lsu_burst #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .MISALIGNED_EN(0), .TIMEOUT_CYCLES(0)) dut_na (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_start(start_b), .i_store(i_store),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_store_data(i_store_data),
    .o_busy(nb_busy), .o_done(nb_done), .o_err(nb_err), .o_load_data(nb_load),
    .o_mem_req(nb_req), .o_mem_we(nb_we), .o_mem_addr(nb_addr),
    .o_mem_be(nb_be), .o_mem_wdata(nb_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] rd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rd1;
    logic        err;
    logic [31:0] ld;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
  } beat_t;

  typedef struct {
    logic        st;
    logic        err;
    logic [31:0] ld;
  } resp_t;

  beat_t bq[$];
  resp_t rq[$];
  vec_t  vt[15];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sd);
    i_store      = st;
    i_funct3     = f3;
    i_addr       = addr;
    i_store_data = sd;
  endtask

  // Push expected beats/response, issue the request, then serve beats from the queue.
  task automatic run_vec(input vec_t v, input bit poke_resp);
    beat_t b;
    resp_t r;
    bit    done;
    if (v.nb >= 1) bq.push_back('{v.a0, v.be0, v.st, v.wd0, v.rd0});
    if (v.nb == 2) bq.push_back('{v.a1, v.be1, v.st, v.wd1, v.rd1});
    rq.push_back('{v.st, v.err, v.ld});
    @(posedge clk); #1;
    drive_req(v.st, v.f3, v.addr, v.sdata);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    done = 1'b0;
    for (int it = 0; it < 40 && !done; it++) begin
      if (it > 0) begin
        @(posedge clk); #1;
      end
      i_mem_ready = 1'b0;
      if (o_mem_req) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got beat at %h expected none", o_mem_addr);
        end else begin
          b = bq.pop_front();
          chk("beat_addr", o_mem_addr, b.a);
          chk("beat_be", 32'(o_mem_be), 32'(b.be));
          chk("beat_we", 32'(o_mem_we), 32'(b.we));
          if (b.we) chk("beat_wdata", o_mem_wdata, b.wd);
          i_mem_ready = 1'b1;
          i_mem_rdata = b.rd;
        end
      end
      if (o_done) begin
        done = 1'b1;
        r = rq.pop_front();
        chk("latency", 32'(it), 32'(v.nb));
        chk("err", 32'(o_err), 32'(r.err));
        chk("busy_resp", 32'(o_busy), 32'd1);
        chk("beats_left", 32'(bq.size()), 32'd0);
        if (!r.st && !r.err) chk("load_data", o_load_data, r.ld);
        if (poke_resp) begin
          i_start = 1'b1;
          @(posedge clk); #1;
          i_start = 1'b0;
          chk("start_in_resp_busy", 32'(o_busy), 32'd0);
          chk("start_in_resp_req", 32'(o_mem_req), 32'd0);
        end
      end
    end
    i_mem_ready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no o_done expected o_done for addr %h", v.addr);
      bq.delete();
      rq.delete();
    end
  endtask

  initial begin
    bit          got;
    int          reqc;
    int          w;
    logic [31:0] last_a;

    //       st    f3      addr          sdata         nb a0            be0      wd0           rd0           a1            be1      wd1           rd1           err   ld
    vt[0]  = '{1'b1, 3'b000, 32'h103,      32'hA5,       1, 32'h100,      4'b1000, 32'hA5000000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 32'h0};
    vt[1]  = '{1'b0, 3'b001, 32'h102,      32'h0,        1, 32'h100,      4'b1100, 32'h0,        32'h80011234, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 32'hFFFF8001};
    vt[2]  = '{1'b0, 3'b010, 32'h203,      32'h0,        2, 32'h200,      4'b1000, 32'h0,        32'h44000000, 32'h204,      4'b0111, 32'h0,        32'h00332211, 1'b0, 32'h33221144};
    vt[3]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 1, 32'h10,       4'b1111, 32'hDEADBEEF, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 32'h0};
    vt[4]  = '{1'b0, 3'b100, 32'h21,       32'h0,        1, 32'h20,       4'b0010, 32'h0,        32'h1234F0AB, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 32'h000000F0};
    vt[5]  = '{1'b0, 3'b000, 32'h21,       32'h0,        1, 32'h20,       4'b0010, 32'h0,        32'h1234F0AB, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 32'hFFFFFFF0};
    vt[6]  = '{1'b0, 3'b101, 32'h33,       32'h0,        2, 32'h30,       4'b1000, 32'h0,        32'hAB000000, 32'h34,       4'b0001, 32'h0,        32'h000000CD, 1'b0, 32'h0000CDAB};
    vt[7]  = '{1'b1, 3'b001, 32'h7,        32'h1234,     2, 32'h4,        4'b1000, 32'h34000000, 32'h0,        32'h8,        4'b0001, 32'h00000012, 32'h0,        1'b0, 32'h0};
    vt[8]  = '{1'b1, 3'b010, 32'h206,      32'hAABBCCDD, 2, 32'h204,      4'b1100, 32'hCCDD0000, 32'h0,        32'h208,      4'b0011, 32'h0000AABB, 32'h0,        1'b0, 32'h0};
    vt[9]  = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,        2, 32'hFFFFFFFC, 4'b1100, 32'h0,        32'h55660000, 32'h0,        4'b0011, 32'h0,        32'h00007788, 1'b0, 32'h77885566};
    vt[10] = '{1'b0, 3'b001, 32'h101,      32'h0,        1, 32'h100,      4'b0110, 32'h0,        32'h00ABCD00, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 32'hFFFFABCD};
    vt[11] = '{1'b0, 3'b011, 32'h40,       32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 32'h0};
    vt[12] = '{1'b1, 3'b100, 32'h40,       32'hFF,       0, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 32'h0};
    vt[13] = '{1'b0, 3'b111, 32'h40,       32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 32'h0};
    vt[14] = '{1'b1, 3'b000, 32'h52,       32'h5A,       1, 32'h50,       4'b0100, 32'h005A0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 32'h0};

    rst = 1'b0;
    clk_en = 1'b1;
    i_start = 1'b0;
    start_b = 1'b0;
    i_mem_ready = 1'b0;
    i_mem_rdata = 32'h0;
    drive_req(1'b0, 3'b010, 32'h0, 32'h0);

    #12;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_be", 32'(o_mem_be), 32'd0);
    chk("rst_load", o_load_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vt[i], i == 3);

    // Misalignment rejected when splitting is disabled.
    @(posedge clk); #1;
    drive_req(1'b0, 3'b010, 32'h202, 32'h0);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("na_done", 32'(nb_done), 32'd1);
    chk("na_err", 32'(nb_err), 32'd1);
    chk("na_req", 32'(nb_req), 32'd0);
    @(posedge clk); #1;
    chk("na_idle_busy", 32'(nb_busy), 32'd0);
    chk("na_idle_done", 32'(nb_done), 32'd0);

    // Timeout with memory never ready.
    @(posedge clk); #1;
    drive_req(1'b0, 3'b010, 32'h300, 32'h0);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    got = 1'b0;
    reqc = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (o_mem_req) reqc++;
      if (o_done) begin
        got = 1'b1;
        chk("to_err", 32'(o_err), 32'd1);
      end
    end
    chk("to_req_cycles", 32'(reqc), 32'd8);
    chk("to_done_seen", 32'(got), 32'd1);

    // Six wait cycles per beat: counter must restart for the second beat.
    @(posedge clk); #1;
    drive_req(1'b0, 3'b010, 32'h203, 32'h0);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    got = 1'b0;
    w = 0;
    last_a = 32'hFFFFFFFF;
    for (int k = 0; k < 60 && !got; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      i_mem_ready = 1'b0;
      if (o_mem_req) begin
        if (o_mem_addr != last_a) begin
          last_a = o_mem_addr;
          w = 0;
        end
        if (w == 6) begin
          i_mem_ready = 1'b1;
          i_mem_rdata = (o_mem_addr == 32'h200) ? 32'h44000000 : 32'h00332211;
        end else begin
          w++;
        end
      end
      if (o_done) begin
        got = 1'b1;
        chk("wait_err", 32'(o_err), 32'd0);
        chk("wait_load", o_load_data, 32'h33221144);
      end
    end
    i_mem_ready = 1'b0;
    chk("wait_done_seen", 32'(got), 32'd1);

    // clk_en low freezes an in-flight beat even with ready high.
    @(posedge clk); #1;
    drive_req(1'b1, 3'b010, 32'h60, 32'h01020304);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    clk_en = 1'b0;
    i_mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("freeze_req", 32'(o_mem_req), 32'd1);
      chk("freeze_done", 32'(o_done), 32'd0);
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    chk("unfreeze_done", 32'(o_done), 32'd1);
    chk("unfreeze_err", 32'(o_err), 32'd0);

    // Asynchronous reset while in the second beat.
    @(posedge clk); #1;
    drive_req(1'b0, 3'b010, 32'h203, 32'h0);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_mem_ready = 1'b1;
    i_mem_rdata = 32'h44000000;
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    chk("b1_req", 32'(o_mem_req), 32'd1);
    chk("b1_addr", o_mem_addr, 32'h204);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(o_mem_req), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_be", 32'(o_mem_be), 32'd0);
    chk("arst_we", 32'(o_mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vt[3], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
